// File: rtl/fifo_param.sv
// ---------------------------------------------------------------------------
// fifo_param
//   Parametrised single-clock FIFO for the PCIe transmit-layer datapath,
//   between the lane distributors and the transmit serialisers.
//   Depth D = 2**address_width words of data_width bits.
//
//   Optional build macro:
//     FIFO_FWFT_EN  first-word fall-through: data_out shows the head word
//                   combinationally and data_valid = !empty_fifo; rd_enable
//                   pops the displayed word. When undefined, reads are
//                   registered: data_out/data_valid update on the edge that
//                   accepts the read.
//
//   Ports
//     clk                  clock, all state on rising edge
//     reset                asynchronous, active-low; clears pointers/count/error
//     wr_enable, data_in   write request and data
//     rd_enable            read request (pop in FWFT mode)
//     almost_full_thresh   almost_full_fifo  when data_count >= thresh
//     almost_empty_thresh  almost_empty_fifo when data_count <= thresh
//     data_out, data_valid read data and its valid strobe
//     data_count           occupancy 0..D
//     full_fifo, empty_fifo, almost_full_fifo, almost_empty_fifo  status flags
//     error                sticky: set on rejected write or rejected read
// ---------------------------------------------------------------------------
module fifo_param #(
    parameter int data_width    = 6,
    parameter int address_width = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_enable,
    input  logic                   rd_enable,
    input  logic [data_width-1:0]  data_in,
    input  logic [address_width:0] almost_full_thresh,
    input  logic [address_width:0] almost_empty_thresh,
    output logic [data_width-1:0]  data_out,
    output logic                   data_valid,
    output logic [address_width:0] data_count,
    output logic                   full_fifo,
    output logic                   empty_fifo,
    output logic                   almost_full_fifo,
    output logic                   almost_empty_fifo,
    output logic                   error
);

    localparam int DEPTH = 1 << address_width;
    localparam logic [address_width:0]   DEPTH_C = DEPTH[address_width:0];
    localparam logic [address_width:0]   CNT_ONE = {{address_width{1'b0}}, 1'b1};
    localparam logic [address_width-1:0] PTR_ONE = {{(address_width-1){1'b0}}, 1'b1};

    logic [data_width-1:0]    mem [DEPTH];
    logic [address_width-1:0] wr_ptr;
    logic [address_width-1:0] rd_ptr;
    logic                     rd_acc;
    logic                     wr_acc;

    // Status flags decode the registered count only; the pointers alone
    // cannot tell full from empty once they wrap onto each other.
    assign empty_fifo        = (data_count == '0);
    assign full_fifo         = (data_count == DEPTH_C);
    assign almost_full_fifo  = (data_count >= almost_full_thresh);
    assign almost_empty_fifo = (data_count <= almost_empty_thresh);

    // No read-through-write bypass: an empty FIFO never accepts a read.
    // A full FIFO may still take a write when the same edge pops a word.
    assign rd_acc = rd_enable && !empty_fifo;
    assign wr_acc = wr_enable && (!full_fifo || rd_acc);

    // Storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_count <= '0;
            error      <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   data_count <= data_count + CNT_ONE;
                2'b01:   data_count <= data_count - CNT_ONE;
                default: data_count <= data_count;
            endcase
            if ((wr_enable && !wr_acc) || (rd_enable && !rd_acc))
                error <= 1'b1;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is always on the output; rd_enable acknowledges it.
    assign data_out   = mem[rd_ptr];
    assign data_valid = !empty_fifo;
`else
    // Registered read: word and strobe appear on the accepting edge;
    // data_out holds its last value between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            if (rd_acc)
                data_out <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_param
//   Self-checking bench for fifo_param (data_width=6, address_width=2).
//   A reference queue tracks FIFO contents; words popped by accepted reads
//   go to a scoreboard queue and are compared when the DUT strobes
//   data_valid. Honors FIFO_FWFT_EN for the output-side expectations.
// ---------------------------------------------------------------------------
module tb_fifo_param;

    localparam int DW = 6;
    localparam int AW = 2;
    localparam int D  = 1 << AW;

    logic          clk;
    logic          reset;
    logic          wr_enable;
    logic          rd_enable;
    logic [DW-1:0] data_in;
    logic [AW:0]   almost_full_thresh;
    logic [AW:0]   almost_empty_thresh;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic [AW:0]   data_count;
    logic          full_fifo;
    logic          empty_fifo;
    logic          almost_full_fifo;
    logic          almost_empty_fifo;
    logic          error;

    fifo_param #(.data_width(DW), .address_width(AW)) dut (
        .clk                (clk),
        .reset              (reset),
        .wr_enable          (wr_enable),
        .rd_enable          (rd_enable),
        .data_in            (data_in),
        .almost_full_thresh (almost_full_thresh),
        .almost_empty_thresh(almost_empty_thresh),
        .data_out           (data_out),
        .data_valid         (data_valid),
        .data_count         (data_count),
        .full_fifo          (full_fifo),
        .empty_fifo         (empty_fifo),
        .almost_full_fifo   (almost_full_fifo),
        .almost_empty_fifo  (almost_empty_fifo),
        .error              (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] model_q[$];   // reference FIFO contents
    logic [DW-1:0] exp_q[$];     // scoreboard: words due on data_out
    logic          m_err;
    logic [DW-1:0] last_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input bit ra);
        int sz;
        sz = model_q.size();
        chk("count",        32'(data_count),        32'(sz));
        chk("empty",        32'(empty_fifo),        32'(sz == 0));
        chk("full",         32'(full_fifo),         32'(sz == D));
        chk("almost_full",  32'(almost_full_fifo),  32'(sz >= int'(almost_full_thresh)));
        chk("almost_empty", 32'(almost_empty_fifo), 32'(sz <= int'(almost_empty_thresh)));
        chk("error",        32'(error),             32'(m_err));
`ifdef FIFO_FWFT_EN
        chk("valid", 32'(data_valid), 32'(sz != 0));
        if (sz != 0)
            chk("dout_fwft", 32'(data_out), 32'(model_q[0]));
`else
        chk("valid", 32'(data_valid), 32'(ra));
        if (data_valid) begin
            if (exp_q.size() == 0)
                chk("sb_depth", 32'(exp_q.size()), 32'd1);
            else begin
                last_out = exp_q.pop_front();
                chk("dout", 32'(data_out), 32'(last_out));
            end
        end else begin
            chk("dout_hold", 32'(data_out), 32'(last_out));
        end
`endif
    endtask

    // One clock with the given request; the model decides acceptance from
    // its own occupancy before the edge.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        int sz;
        bit ra, wa;
        wr_enable = w;
        rd_enable = r;
        data_in   = d;
        sz = model_q.size();
        ra = r && (sz != 0);
        wa = w && ((sz < D) || ra);
        if ((w && !wa) || (r && !ra))
            m_err = 1'b1;
        @(posedge clk);
        #1;
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(d);
        wr_enable = 1'b0;
        rd_enable = 1'b0;
`ifdef FIFO_FWFT_EN
        exp_q.delete();
`endif
        check_outputs(ra);
    endtask

    // Asserts reset between edges and checks the cleared state before any
    // clock arrives, then releases on a falling edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_q.delete();
        exp_q.delete();
        m_err    = 1'b0;
        last_out = '0;
        check_outputs(1'b0);
`ifndef FIFO_FWFT_EN
        chk("reset_dout", 32'(data_out), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset               = 1'b1;
        wr_enable           = 1'b0;
        rd_enable           = 1'b0;
        data_in             = '0;
        almost_full_thresh  = 3'd3;
        almost_empty_thresh = 3'd1;
        m_err               = 1'b0;
        last_out            = '0;
        #2;

        // Reset then idle
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);

        // Fill, then overflow attempt
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b0, 6'h3F);

        // Drain, then underflow attempt
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);

        // Full FIFO under continuous write+read across pointer wrap
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, DW'(8'h10 + i));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);

        // Write+read on empty: read rejected (no bypass), write taken
        step(1'b1, 1'b1, 6'h15);
        step(1'b0, 1'b1, '0);

        // Reset mid-operation discards stored words
        do_reset();
        step(1'b1, 1'b0, 6'h11);
        step(1'b1, 1'b0, 6'h22);
        do_reset();
        step(1'b1, 1'b0, 6'h2A);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);

        // Threshold extremes: almost_full at thresh 0, never above D
        almost_full_thresh  = 3'd0;
        almost_empty_thresh = 3'd4;
        do_reset();
        step(1'b1, 1'b0, 6'h05);
        almost_full_thresh  = 3'd5;
        almost_empty_thresh = 3'd0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(8'h30 + i));

        // Randomised mix
        almost_full_thresh  = 3'd3;
        almost_empty_thresh = 3'd1;
        do_reset();
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
